// File: rtl/l2_data_pkg.sv
// Shared constants and types for the L2 data array front-end controller.
// Geometry is fixed to the 128 x 128b macro with byte write enables.
package l2_data_pkg;

    localparam int ADDR_WIDTH = 7;
    localparam int DATA_WIDTH = 128;
    localparam int NUM_WMASKS = DATA_WIDTH / 8;
    localparam int NUM_ROWS   = 1 << ADDR_WIDTH;

    localparam logic [NUM_WMASKS-1:0] WMASK_ALL = '1;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [NUM_WMASKS-1:0] wmask;
        logic [DATA_WIDTH-1:0] data;
    } wreq_t;

endpackage

// File: rtl/l2_rsp_fifo.sv
// Small in-order read-response buffer; the head entry is a register so the
// response data is stable while the consumer stalls.
module l2_rsp_fifo
    import l2_data_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign full     = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/l2_data_array_ctrl.sv
// L2 data array front end: zero sweep, two-way RR write arbitration, credited reads.
// Optional L2_DATA_WRITE_FORWARD_EN forwards full-mask write data to colliding reads.
module l2_data_array_ctrl
    import l2_data_pkg::*;
#(
    parameter int RSP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr0_valid,
    output logic                  wr0_ready,
    input  logic [ADDR_WIDTH-1:0] wr0_addr,
    input  logic [NUM_WMASKS-1:0] wr0_wmask,
    input  logic [DATA_WIDTH-1:0] wr0_data,
    input  logic                  wr1_valid,
    output logic                  wr1_ready,
    input  logic [ADDR_WIDTH-1:0] wr1_addr,
    input  logic [NUM_WMASKS-1:0] wr1_wmask,
    input  logic [DATA_WIDTH-1:0] wr1_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] cnt_reg;
    logic                  init_done_reg;
    logic                  last_reg;
    logic                  inflight_reg;
    logic                  fwd_reg;
    logic [DATA_WIDTH-1:0] fwd_data_reg;

    wreq_t            req0, req1, gnt_req;
    logic             gnt0, gnt1, any_gnt;
    logic             collide, fwd_ok, stall, credit, rd_fire;
    logic [CNT_W-1:0] rsp_count;
    logic [CNT_W:0]   occ;
    logic             fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] push_data;

    assign req0    = '{addr: wr0_addr, wmask: wr0_wmask, data: wr0_data};
    assign req1    = '{addr: wr1_addr, wmask: wr1_wmask, data: wr1_data};

    // last_reg = 1 means wr1 was granted last, so wr0 wins the next tie.
    assign gnt0    = (state_reg == S_RUN) & wr0_valid & (~wr1_valid | last_reg);
    assign gnt1    = (state_reg == S_RUN) & wr1_valid & ~gnt0;
    assign any_gnt = gnt0 | gnt1;
    assign gnt_req = gnt1 ? req1 : req0;

    assign wr0_ready = gnt0;
    assign wr1_ready = gnt1;

    always_comb begin
        state_next  = state_reg;
        sram_csb0   = 1'b1;
        sram_addr0  = gnt_req.addr;
        sram_wmask0 = gnt_req.wmask;
        sram_din0   = gnt_req.data;
        case (state_reg)
            S_INIT: begin
                // Gated by rst_n so the macro port is idle while reset is held.
                sram_csb0   = ~rst_n;
                sram_addr0  = cnt_reg;
                sram_wmask0 = WMASK_ALL;
                sram_din0   = '0;
                if (&cnt_reg) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                sram_csb0 = ~any_gnt;
            end
            default: state_next = S_INIT;
        endcase
    end

    assign collide = rd_valid & any_gnt & (rd_addr == gnt_req.addr);
`ifdef L2_DATA_WRITE_FORWARD_EN
    assign fwd_ok  = collide & (gnt_req.wmask == WMASK_ALL);
`else
    assign fwd_ok  = 1'b0;
`endif
    assign stall   = collide & ~fwd_ok;

    // Credit counts in-flight reads; a pop in the same cycle is not credited.
    assign occ      = {1'b0, rsp_count} + (CNT_W+1)'(inflight_reg);
    assign credit   = ~fifo_full & (occ < (CNT_W+1)'(RSP_DEPTH));
    assign rd_ready = init_done_reg & credit & ~stall;
    assign rd_fire  = rd_valid & rd_ready;

    assign sram_csb1  = ~(rd_fire & ~fwd_ok);
    assign sram_addr1 = rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_INIT;
            cnt_reg       <= '0;
            init_done_reg <= 1'b0;
            last_reg      <= 1'b1;
            inflight_reg  <= 1'b0;
            fwd_reg       <= 1'b0;
            fwd_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_INIT) begin
                cnt_reg <= cnt_reg + ADDR_WIDTH'(1);
            end
            if ((state_reg == S_INIT) && (state_next == S_RUN)) begin
                init_done_reg <= 1'b1;
            end
            if (any_gnt) begin
                last_reg <= gnt1;
            end
            inflight_reg <= rd_fire;
            fwd_reg      <= rd_fire & fwd_ok;
            if (rd_fire & fwd_ok) begin
                fwd_data_reg <= gnt_req.data;
            end
        end
    end

    assign push_data = fwd_reg ? fwd_data_reg : sram_dout1;
    assign init_done = init_done_reg;
    assign rsp_valid = ~fifo_empty;

    l2_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_reg),
        .push_data (push_data),
        .pop       (rsp_ready),
        .pop_data  (rsp_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rsp_count)
    );

endmodule

// File: doc/l2_data_array_ctrl.md
Name: l2_data_array_ctrl

Overview:
Front-end controller for the L2 data array, a 128 x 128b SRAM macro with one write port (port 0, byte-masked) and one read port (port 1).
- Zero-initialises every row after reset.
- Round-robin arbitrates two write requesters: refill and store-merge.
- Accepts one read per cycle with valid/ready flow control and buffers read responses.
- Resolves same-cycle read/write address collisions.
- Sits between the L2 cache FSM and the SRAM macro; drives the macro pins directly.

Parameters:
ADDR_WIDTH, 7, row address bits (128 rows)
DATA_WIDTH, 128, row width in bits
NUM_WMASKS, 16, byte-enable count (DATA_WIDTH/8)
RSP_DEPTH, 2, read-response buffer entries (power of 2, >=2)

Ports:
clk  in  1  single clock; macro clk0/clk1 tie to it
rst_n  in  1  asynchronous active-low reset
wr0_valid/wr0_ready  in/out  1/1  refill write handshake
wr0_addr, wr0_wmask, wr0_data  in  ADDR_WIDTH, NUM_WMASKS, DATA_WIDTH  refill write payload
wr1_valid/wr1_ready  in/out  1/1  store-merge write handshake
wr1_addr, wr1_wmask, wr1_data  in  ADDR_WIDTH, NUM_WMASKS, DATA_WIDTH  store-merge write payload
rd_valid/rd_ready  in/out  1/1  read request handshake
rd_addr  in  ADDR_WIDTH  read row
rsp_valid/rsp_ready  out/in  1/1  read response handshake
rsp_data  out  DATA_WIDTH  read row data
init_done  out  1  high once the zero sweep completes
sram_csb0, sram_wmask0, sram_addr0, sram_din0  out  1, NUM_WMASKS, ADDR_WIDTH, DATA_WIDTH  macro write port (csb active-low)
sram_csb1, sram_addr1  out  1, ADDR_WIDTH  macro read port
sram_dout1  in  DATA_WIDTH  macro read data

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- Reset values: all readys = 0, rsp_valid = 0, rsp_data = 0, init_done = 0, sram_csb0 = 1, sram_csb1 = 1. FSM enters S_INIT with row counter = 0 and the RR pointer favouring wr0.
- Reset mid-operation: all in-flight reads and buffered responses are dropped; the init sweep restarts.
- S_INIT:
  - Each cycle: sram_csb0 = 0, addr0 = counter, din0 = 0, wmask0 = all ones. Counter increments each cycle.
  - After the edge that issues row 127, go to S_RUN and set init_done = 1. This is the 128th edge after reset release.
  - The read port stays idle throughout.
- S_RUN, write arbitration:
  - A single valid requester is granted at once.
  - If both are valid, grant the requester not granted last; the pointer updates only on a grant.
  - wrN_ready = grant to N. Macro port 0 is driven combinationally from the granted payload; sram_csb0 = ~(any grant).
- S_RUN, reads:
  - rd_ready = init_done AND (buffer occupancy + in-flight reads < RSP_DEPTH) AND no blocking collision.
  - A same-cycle rsp pop does not add credit.
  - Reads are driven combinationally: sram_csb1 = ~(rd_valid & rd_ready), sram_addr1 = rd_addr.
- Read latency: a read accepted at edge N has its macro data captured into the response buffer at edge N+1. rsp_valid is high after edge N+1. rsp_data comes from a register; responses are returned in order.
- Buffer: when full, rsp_valid stays high and rsp_data is held until rsp_ready.
- Collision: rd_valid with rd_addr equal to the granted write address in the same cycle. Default: rd_ready = 0 that cycle and the write proceeds. The read is accepted on a later cycle.
- Back-to-back: a write at edge N followed by a read of the same row at edge N+1 returns the new data; no stall.

Optional Feature:
L2_DATA_WRITE_FORWARD_EN:
- Defined: on a collision where the granted wmask is all ones, the read is accepted without enabling macro port 1 (sram_csb1 = 1). The write data is forwarded into the response buffer with the same latency as a macro read.
- Partial-mask collisions still stall.
- Undefined: every collision stalls the read.

Decomposition:
- Package l2_data_pkg holds:
  - ADDR_WIDTH, DATA_WIDTH, NUM_WMASKS constants
  - WMASK_ALL constant
  - state enum {S_INIT, S_RUN}
  - write-request struct {addr, wmask, data}
- Sub-module l2_rsp_fifo: RSP_DEPTH-entry synchronous FIFO with push, pop, full, occupancy count and async active-low reset.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Reset release -> sram_csb0 = 0 for exactly 128 cycles over addrs 0..127, din0 = 0; init_done rises on the 128th edge; all readys are 0 until then.
- Write row 5 = 0xA5 pattern (full mask), then read row 5 on the next cycle -> rsp_valid one cycle after acceptance, rsp_data = 0xA5 pattern.
- wr0 and wr1 both valid for 4 cycles -> grants alternate wr0, wr1, wr0, wr1; then only wr1 valid -> wr1 granted immediately.
- Write row 9 and read row 9 in the same cycle -> without the macro, rd_ready = 0 and the read completes next cycle with the new data. With L2_DATA_WRITE_FORWARD_EN and full mask, the read is accepted, sram_csb1 = 1 and the forwarded data is returned. With mask 0x0001, the read still stalls.
- rsp_ready held 0 while issuing reads -> at most 2 accepted, rd_ready = 0 thereafter. Releasing rsp_ready drains in order with data intact.
- Assert rst_n low with a read in flight and the buffer holding 1 entry -> rsp_valid = 0 at once, macro csb pins = 1, init sweep restarts.
